// File: rtl/secded_decoder_if.sv
// Read-path bus between a SECDED decoder and the logic either side of it.
// master drives the received word in and collects the corrected result; slave is the decoder.
interface secded_decoder_if #(
  parameter int DATA_BITS   = 128,
  parameter int PARITY_BITS = 9
);
  logic [DATA_BITS:1]     Data_in;
  logic [PARITY_BITS:1]   Parity_in;
  logic                   Data_valid_in;
  logic [DATA_BITS:1]     Data_out;
  logic                   Data_valid_out;
  logic [PARITY_BITS-1:1] Syndrome_out;
  logic                   Sec_err;
  logic                   Ded_err;

  modport master (
    output Data_in, Parity_in, Data_valid_in,
    input  Data_out, Data_valid_out, Syndrome_out, Sec_err, Ded_err
  );

  modport slave (
    input  Data_in, Parity_in, Data_valid_in,
    output Data_out, Data_valid_out, Syndrome_out, Sec_err, Ded_err
  );
endinterface

// File: rtl/secded_decoder.sv
// Two-stage SECDED decoder: registers the received word, recomputes the syndrome, corrects or flags it.
// Define SECDED_ERR_CNT_EN to build the saturating single/double error statistics counters.
module secded_decoder #(
  parameter int DATA_BITS   = 128,
  parameter int PARITY_BITS = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  secded_decoder_if.slave      bus,
  input  logic                 Cnt_clear,
  output logic [CNT_WIDTH-1:0] Sec_cnt,
  output logic [CNT_WIDTH-1:0] Ded_cnt
);

  localparam int SYN_W = PARITY_BITS - 1;
  localparam logic [SYN_W-1:0] LAST_POS = SYN_W'(DATA_BITS + PARITY_BITS - 1);

  // Codeword position of data bit j: the j-th non-power-of-two position counting from 3.
  function automatic int data_pos(input int j);
    int cnt;
    data_pos = 0;
    cnt = 0;
    for (int p = 3; p <= DATA_BITS + PARITY_BITS - 1; p++) begin
      if ((p & (p - 1)) != 0) begin
        cnt++;
        if (cnt == j && data_pos == 0) data_pos = p;
      end
    end
  endfunction

  logic [DATA_BITS:1]   data_q;
  logic [PARITY_BITS:1] parity_q;
  logic                 valid_q;

  logic [SYN_W-1:0]     pos_term [1:DATA_BITS];
  logic [DATA_BITS:1]   pos_hit;
  logic [SYN_W-1:0]     syndrome;
  logic                 overall;
  logic                 sec_det;
  logic                 ded_det;
  logic [DATA_BITS:1]   data_fix;

  logic [DATA_BITS:1]   data_out_q;
  logic [SYN_W-1:0]     syndrome_q;
  logic                 sec_q;
  logic                 ded_q;
  logic                 valid_out_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_q   <= '0;
      parity_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.Data_valid_in;
      if (bus.Data_valid_in) begin
        data_q   <= bus.Data_in;
        parity_q <= bus.Parity_in;
      end
    end
  end

  // Each data bit contributes its position to the syndrome; pos_hit marks the bit the syndrome points at.
  for (genvar j = 1; j <= DATA_BITS; j++) begin : g_map
    localparam logic [SYN_W-1:0] POS = SYN_W'(data_pos(j));
    assign pos_term[j] = data_q[j] ? POS : '0;
    assign pos_hit[j]  = (syndrome == POS);
  end

  always_comb begin
    syndrome = parity_q[SYN_W:1];
    for (int j = 1; j <= DATA_BITS; j++) begin
      syndrome = syndrome ^ pos_term[j];
    end
  end

  // Odd overall parity with an in-range syndrome is one flip; parity-bit positions never match pos_hit.
  assign overall  = (^data_q) ^ (^parity_q);
  assign sec_det  = overall && (syndrome <= LAST_POS);
  assign ded_det  = overall ? (syndrome > LAST_POS) : (syndrome != '0);
  assign data_fix = data_q ^ (pos_hit & {DATA_BITS{overall}});

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_out_q  <= '0;
      syndrome_q  <= '0;
      sec_q       <= 1'b0;
      ded_q       <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= valid_q;
      if (valid_q) begin
        data_out_q <= data_fix;
        syndrome_q <= syndrome;
        sec_q      <= sec_det;
        ded_q      <= ded_det;
      end
    end
  end

  assign bus.Data_out       = data_out_q;
  assign bus.Syndrome_out   = syndrome_q;
  assign bus.Sec_err        = sec_q;
  assign bus.Ded_err        = ded_q;
  assign bus.Data_valid_out = valid_out_q;

`ifdef SECDED_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] sec_cnt_q;
  logic [CNT_WIDTH-1:0] ded_cnt_q;

  // Counts words as they leave the decoder; clear beats a coincident increment, counts stick at all-ones.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else if (Cnt_clear) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      if (valid_out_q && sec_q && sec_cnt_q != '1) sec_cnt_q <= sec_cnt_q + CNT_WIDTH'(1);
      if (valid_out_q && ded_q && ded_cnt_q != '1) ded_cnt_q <= ded_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign Sec_cnt = sec_cnt_q;
  assign Ded_cnt = ded_cnt_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = Cnt_clear;
  assign Sec_cnt = '0;
  assign Ded_cnt = '0;
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// Scoreboard bench for secded_decoder: directed codewords, mid-stream reset, counter saturation and clear.
// Counter expectations follow SECDED_ERR_CNT_EN; without it the counters must stay 0.
module tb_secded_decoder;

  localparam int DATA_BITS   = 128;
  localparam int PARITY_BITS = 9;
  localparam int CNT_WIDTH   = 4;
`ifdef SECDED_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_BITS:1]     data;
    logic [PARITY_BITS-1:1] syn;
    logic                   sec;
    logic                   ded;
  } exp_t;

  logic                 clk;
  logic                 reset_b;
  logic                 Cnt_clear;
  logic [CNT_WIDTH-1:0] Sec_cnt;
  logic [CNT_WIDTH-1:0] Ded_cnt;

  secded_decoder_if #(.DATA_BITS(DATA_BITS), .PARITY_BITS(PARITY_BITS)) bus ();

  secded_decoder #(
    .DATA_BITS(DATA_BITS),
    .PARITY_BITS(PARITY_BITS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus),
    .Cnt_clear(Cnt_clear),
    .Sec_cnt(Sec_cnt),
    .Ded_cnt(Ded_cnt)
  );

  exp_t exp_q[$];
  exp_t last_exp = '0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  logic                 cnt_probe = 1'b0;
  logic                 end_probe = 1'b0;
  logic [CNT_WIDTH-1:0] exp_sec_cnt = '0;
  logic [CNT_WIDTH-1:0] exp_ded_cnt = '0;

  localparam logic [DATA_BITS:1] D_ZERO = '0;
  localparam logic [DATA_BITS:1] D_B1   = 128'h1;
  localparam logic [DATA_BITS:1] D_B12  = 128'h3;
  localparam logic [DATA_BITS:1] D_B3   = 128'h4;
  localparam logic [DATA_BITS:1] D_B128 = {1'b1, 127'b0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: run did not finish within 20000 time units");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_BITS:1] d, input logic [PARITY_BITS:1] p,
                               input bit keep, input logic [DATA_BITS:1] ed,
                               input logic [PARITY_BITS-1:1] es, input logic esec, input logic eded);
    exp_t e;
    @(negedge clk);
    bus.Data_in       = d;
    bus.Parity_in     = p;
    bus.Data_valid_in = 1'b1;
    if (keep) begin
      e.data = ed;
      e.syn  = es;
      e.sec  = esec;
      e.ded  = eded;
      exp_q.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.Data_valid_in = 1'b0;
    end
  endtask

  task automatic probeCounters(input int s, input int d);
    @(posedge clk);
    #1;
    exp_sec_cnt = CNT_EN ? CNT_WIDTH'(s) : '0;
    exp_ded_cnt = CNT_EN ? CNT_WIDTH'(d) : '0;
    cnt_probe   = 1'b1;
    @(posedge clk);
    #1;
    cnt_probe = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output pulse, checks hold between pulses and zeros in reset.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_b) begin
      last_exp = '0;
      checkOutput("reset_data", 128'(bus.Data_out), 128'(0));
      checkOutput("reset_ctrl", 128'({bus.Data_valid_out, bus.Syndrome_out, bus.Sec_err, bus.Ded_err, Sec_cnt, Ded_cnt}), 128'(0));
    end else if (bus.Data_valid_out) begin
      checkOutput("pending_word", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("data", 128'(bus.Data_out), 128'(e.data));
        checkOutput("syndrome", 128'(bus.Syndrome_out), 128'(e.syn));
        checkOutput("sec_ded", 128'({bus.Sec_err, bus.Ded_err}), 128'({e.sec, e.ded}));
        last_exp = e;
      end
    end else begin
      checkOutput("hold_data", 128'(bus.Data_out), 128'(last_exp.data));
      checkOutput("hold_flags", 128'({bus.Syndrome_out, bus.Sec_err, bus.Ded_err}),
                  128'({last_exp.syn, last_exp.sec, last_exp.ded}));
    end
    if (cnt_probe) begin
      checkOutput("sec_cnt", 128'(Sec_cnt), 128'(exp_sec_cnt));
      checkOutput("ded_cnt", 128'(Ded_cnt), 128'(exp_ded_cnt));
    end
    if (end_probe) begin
      checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));
    end
  end

  initial begin
    reset_b           = 1'b1;
    Cnt_clear         = 1'b0;
    bus.Data_in       = '0;
    bus.Parity_in     = '0;
    bus.Data_valid_in = 1'b0;
    #2 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;

    // Directed codewords, issued back to back.
    applyStimulus(D_ZERO, 9'h000, 1'b1, D_ZERO, 8'd0,   1'b0, 1'b0);
    applyStimulus(D_B1,   9'h000, 1'b1, D_ZERO, 8'd3,   1'b1, 1'b0);
    applyStimulus(D_ZERO, 9'h100, 1'b1, D_ZERO, 8'd0,   1'b1, 1'b0);
    applyStimulus(D_B12,  9'h000, 1'b1, D_B12,  8'd6,   1'b0, 1'b1);
    applyStimulus(D_ZERO, 9'h1F0, 1'b1, D_ZERO, 8'd240, 1'b0, 1'b1);
    applyStimulus(D_B3,   9'h106, 1'b1, D_B3,   8'd0,   1'b0, 1'b0);
    applyStimulus(D_ZERO, 9'h106, 1'b1, D_B3,   8'd6,   1'b1, 1'b0);
    applyStimulus(D_ZERO, 9'h008, 1'b1, D_ZERO, 8'd8,   1'b1, 1'b0);
    applyStimulus(D_B128, 9'h000, 1'b1, D_ZERO, 8'd136, 1'b1, 1'b0);
    applyStimulus(D_ZERO, 9'h089, 1'b1, D_ZERO, 8'd137, 1'b0, 1'b1);
    idleCycles(4);
    probeCounters(5, 3);

    // Two words in flight are discarded by reset; the two after release must decode normally.
    applyStimulus(D_B1,  9'h000, 1'b0, D_ZERO, 8'd0, 1'b0, 1'b0);
    applyStimulus(D_B12, 9'h000, 1'b0, D_ZERO, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_b           = 1'b0;
    bus.Data_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    applyStimulus(D_ZERO, 9'h106, 1'b1, D_B3,   8'd6, 1'b1, 1'b0);
    applyStimulus(D_B1,   9'h000, 1'b1, D_ZERO, 8'd3, 1'b1, 1'b0);
    idleCycles(4);
    probeCounters(2, 0);

    // Saturation of a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(D_B1, 9'h000, 1'b1, D_ZERO, 8'd3, 1'b1, 1'b0);
    end
    idleCycles(4);
    probeCounters(15, 0);

    @(negedge clk);
    Cnt_clear = 1'b1;
    @(negedge clk);
    Cnt_clear = 1'b0;
    idleCycles(2);
    probeCounters(0, 0);

    // Clear coinciding with the increment edge of a single-error word.
    applyStimulus(D_B1, 9'h000, 1'b1, D_ZERO, 8'd3, 1'b1, 1'b0);
    idleCycles(1);
    @(negedge clk);
    Cnt_clear = 1'b1;
    @(negedge clk);
    Cnt_clear = 1'b0;
    idleCycles(3);
    probeCounters(0, 0);

    applyStimulus(D_B1, 9'h000, 1'b1, D_ZERO, 8'd3, 1'b1, 1'b0);
    idleCycles(4);
    probeCounters(1, 0);

    @(posedge clk);
    #1 end_probe = 1'b1;
    @(posedge clk);
    #1 end_probe = 1'b0;
    idleCycles(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
